// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload + valid, flush/bubble/hold control
// decoded from the global stall vector, and saturating bubble/hold counters.
module pipe_stage_reg #(
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        STALL_W     = 6,
    parameter int unsigned        STAGE_IDX   = 2,
    parameter logic [DATA_W-1:0]  NOP_VALUE   = '0,
    parameter logic [DATA_W-1:0]  STICKY_MASK = '0,
    parameter int unsigned        CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               cnt_clr,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_fire,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt
);

    logic              stall_up;
    logic              stall_dn;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  bub_q, bub_d;
    logic [CNT_W-1:0]  hold_q, hold_d;

    assign stall_up = stall[STAGE_IDX];

    // The last stage has no downstream stall bit; it can never be held.
    if (STAGE_IDX < STALL_W - 1) begin : g_dn
        assign stall_dn = stall[STAGE_IDX+1];
    end else begin : g_last
        assign stall_dn = 1'b0;
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        bub_d   = bub_q;
        hold_d  = hold_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = NOP_VALUE;
        end else if (stall_up && !stall_dn) begin
            valid_d = 1'b0;
            data_d  = (NOP_VALUE & ~STICKY_MASK) | (data_q & STICKY_MASK);
            if (bub_q != '1) bub_d = bub_q + 1'b1;
        end else if (stall_up) begin
            if (valid_q && hold_q != '1) hold_d = hold_q + 1'b1;
        end else begin
            // Illegal stall_up=0/stall_dn=1 also lands here and advances.
            valid_d = in_valid;
            data_d  = in_valid ? in_data
                               : (NOP_VALUE & ~STICKY_MASK) | (in_data & STICKY_MASK);
        end
        if (cnt_clr) begin
            bub_d  = '0;
            hold_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VALUE;
            bub_q   <= '0;
            hold_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            bub_q   <= bub_d;
            hold_q  <= hold_d;
        end
    end

    assign in_ready   = ~stall_up;
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_fire   = valid_q & ~stall_dn;
    assign bubble_cnt = bub_q;
    assign hold_cnt   = hold_q;

    a_stall_encoding: assert property (@(posedge clk) disable iff (rst)
        !(!stall_up && stall_dn));

endmodule
